// File: rtl/load_store_unit.sv
// RV32I load/store initiator: single outstanding request toward the 16 kB memory / MMIO port.
// Optional LSU_MISALIGNED_SPLIT_EN splits misaligned accesses; otherwise they are rejected.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data
);

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        split_q, split_d;
    logic        err_q, err_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_legal, req_misal;
    logic [1:0]  size_m1;
    logic [2:0]  span;
    logic        needs_hi;
    logic [31:0] word_base;
    logic [31:0] hi_w, lo_w, shifted, ext;
    logic [7:0]  st_byte;

    always_comb begin
        req_legal = 1'b0;
        if (req_write) req_legal = (req_funct3[2] == 1'b0) && (req_funct3[1:0] != 2'b11);
        else req_legal = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        req_misal = ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                    ((req_funct3[1:0] == 2'b01) && req_addr[0]);
    end

    // Bytes minus one; a second word is needed when the access runs past byte 3.
    assign size_m1   = {funct3_q[1], funct3_q[1] | funct3_q[0]};
    assign span      = {1'b0, addr_q[1:0]} + {1'b0, size_m1};
    assign needs_hi  = span[2];
    assign word_base = {addr_q[31:2], 2'b00};

    assign hi_w    = cnt_q[0] ? mem_read_data : 32'h0;
    assign lo_w    = cnt_q[0] ? lo_q : mem_read_data;
    assign shifted = 32'({hi_w, lo_w} >> {addr_q[1:0], 3'b000});

    always_comb begin
        case (funct3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    always_comb begin
        case (cnt_q)
            2'd0:    st_byte = wdata_q[7:0];
            2'd1:    st_byte = wdata_q[15:8];
            2'd2:    st_byte = wdata_q[23:16];
            default: st_byte = wdata_q[31:24];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        split_d  = split_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        lo_d     = lo_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    split_d  = req_misal;
                    cnt_d    = 2'd0;
                    lo_d     = 32'h0;
                    rdata_d  = 32'h0;
                    err_d    = !req_legal || (req_misal && !SPLIT_EN);
                    state_d  = err_d ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (!write_q) state_d = WAIT;
                else if (split_q && (cnt_q != size_m1)) cnt_d = cnt_q + 2'd1;
                else state_d = RESP;
            end
            WAIT: begin
                if (!split_q) begin
                    rdata_d = mem_read_data;
                    state_d = RESP;
                end else if ((cnt_q == 2'd0) && needs_hi) begin
                    lo_d    = mem_read_data;
                    cnt_d   = 2'd1;
                    state_d = ISSUE;
                end else begin
                    rdata_d = ext;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            split_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 2'd0;
            lo_q     <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            split_q  <= split_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            lo_q     <= lo_d;
            rdata_q  <= rdata_d;
        end
    end

    // Memory pins decode straight from state so reset clears them asynchronously.
    always_comb begin
        req_ready         = (state_q == IDLE);
        rsp_valid         = (state_q == RESP);
        rsp_error         = (state_q == RESP) && err_q;
        rsp_rdata         = (state_q == RESP) ? rdata_q : 32'h0;
        mem_write         = 1'b0;
        mem_funct3        = 3'b010;
        mem_write_address = 32'h0;
        mem_write_data    = 32'h0;
        mem_read_address  = 32'h0;
        if ((state_q == ISSUE) && write_q) begin
            mem_write = 1'b1;
            if (split_q) begin
                mem_funct3        = 3'b000;
                mem_write_address = addr_q + {30'h0, cnt_q};
                mem_write_data    = {24'h0, st_byte};
            end else begin
                mem_funct3        = funct3_q;
                mem_write_address = addr_q;
                mem_write_data    = wdata_q;
            end
        end else if (((state_q == ISSUE) || (state_q == WAIT)) && !write_q) begin
            if (split_q) mem_read_address = word_base + (cnt_q[0] ? 32'd4 : 32'd0);
            else begin
                mem_funct3       = funct3_q;
                mem_read_address = addr_q;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-array memory model
// (registered word read, combinational extract/extend on current address and funct3).
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_address;
    logic [31:0] mem_read_data;

    int tests = 0;
    int fails = 0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_write(mem_write), .mem_funct3(mem_funct3),
        .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
        .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory model
    logic [7:0]  mem [0:1023];
    logic [31:0] rword = 32'h0;
    logic [31:0] rsh;

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_write_address[9:0]] = mem_write_data[7:0];
            if (mem_funct3[1:0] != 2'b00)
                mem[mem_write_address[9:0] + 10'd1] = mem_write_data[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[mem_write_address[9:0] + 10'd2] = mem_write_data[23:16];
                mem[mem_write_address[9:0] + 10'd3] = mem_write_data[31:24];
            end
        end
        rword <= {mem[{mem_read_address[9:2], 2'b11}], mem[{mem_read_address[9:2], 2'b10}],
                  mem[{mem_read_address[9:2], 2'b01}], mem[{mem_read_address[9:2], 2'b00}]};
    end

    always_comb begin
        rsh = rword >> {mem_read_address[1:0], 3'b000};
        case (mem_funct3)
            3'b000:  mem_read_data = {{24{rsh[7]}}, rsh[7:0]};
            3'b100:  mem_read_data = {24'h0, rsh[7:0]};
            3'b001:  mem_read_data = {{16{rsh[15]}}, rsh[15:0]};
            3'b101:  mem_read_data = {16'h0, rsh[15:0]};
            default: mem_read_data = rword;
        endcase
    end

    task automatic put_word(input logic [9:0] a, input logic [31:0] w);
        mem[a]         = w[7:0];
        mem[a + 10'd1] = w[15:8];
        mem[a + 10'd2] = w[23:16];
        mem[a + 10'd3] = w[31:24];
    endtask

    task automatic preload();
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        put_word(10'h100, 32'h8899AABB);
        put_word(10'h104, 32'h11223344);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Per-request observations
    int          lat;
    int          nwr;
    logic [31:0] r_data;
    logic        r_err;
    logic        rdy_after;
    logic [31:0] ra_hist [1:4];
    logic [2:0]  f3_hist [1:4];
    logic [31:0] wr_addr [0:7];
    logic [31:0] wr_data [0:7];

    task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; nwr = 0; r_data = 32'hx; r_err = 1'bx;
        for (int i = 1; i <= 4; i++) begin ra_hist[i] = 32'hx; f3_hist[i] = 3'bx; end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k <= 4) begin ra_hist[k] = mem_read_address; f3_hist[k] = mem_funct3; end
            if (mem_write) begin
                if (nwr < 8) begin wr_addr[nwr] = mem_write_address; wr_data[nwr] = mem_write_data; end
                nwr++;
            end
            if (rsp_valid) begin lat = k; r_data = rsp_rdata; r_err = rsp_error; break; end
        end
        @(negedge clk);
        rdy_after = req_ready;
    endtask

    initial begin
        preload();
        #12;
        // Reset state
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'h0);
        check("rst rsp_error", 32'(rsp_error), 32'd0);
        check("rst mem_write", 32'(mem_write), 32'd0);
        check("rst mem_funct3", 32'(mem_funct3), 32'd2);
        check("rst mem_waddr", mem_write_address, 32'h0);
        check("rst mem_wdata", mem_write_data, 32'h0);
        check("rst mem_raddr", mem_read_address, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Aligned word load
        run_req(1'b0, 3'b010, 32'h100, 32'h0);
        check("lw latency", 32'(lat), 32'd3);
        check("lw data", r_data, 32'h8899AABB);
        check("lw error", 32'(r_err), 32'd0);
        check("lw raddr issue", ra_hist[1], 32'h100);
        check("lw raddr wait", ra_hist[2], 32'h100);
        check("lw funct3 wait", 32'(f3_hist[2]), 32'd2);
        check("lw ready after", 32'(rdy_after), 32'd1);

        run_req(1'b0, 3'b000, 32'h103, 32'h0);
        check("lb data", r_data, 32'hFFFFFF88);
        run_req(1'b0, 3'b100, 32'h103, 32'h0);
        check("lbu data", r_data, 32'h00000088);
        run_req(1'b0, 3'b101, 32'h102, 32'h0);
        check("lhu data", r_data, 32'h00008899);

        // Illegal load funct3
        run_req(1'b0, 3'b011, 32'h100, 32'h0);
        check("ill latency", 32'(lat), 32'd1);
        check("ill error", 32'(r_err), 32'd1);
        check("ill data", r_data, 32'h0);
        check("ill raddr", ra_hist[1], 32'h0);
        check("ill ready after", 32'(rdy_after), 32'd1);

        // Illegal store funct3
        run_req(1'b1, 3'b100, 32'h100, 32'h12345678);
        check("ill st error", 32'(r_err), 32'd1);
        check("ill st writes", 32'(nwr), 32'd0);

        // Aligned half store then readback
        run_req(1'b1, 3'b001, 32'h102, 32'h0000CAFE);
        check("sh writes", 32'(nwr), 32'd1);
        check("sh latency", 32'(lat), 32'd2);
        check("sh waddr", wr_addr[0], 32'h102);
        check("sh rdata", r_data, 32'h0);
        check("sh error", 32'(r_err), 32'd0);
        run_req(1'b0, 3'b010, 32'h100, 32'h0);
        check("lw after sh", r_data, 32'hCAFEAABB);

`ifdef LSU_MISALIGNED_SPLIT_EN
        preload();
        run_req(1'b0, 3'b010, 32'h102, 32'h0);
        check("mis lw latency", 32'(lat), 32'd5);
        check("mis lw data", r_data, 32'h33448899);
        check("mis lw raddr lo", ra_hist[1], 32'h100);
        check("mis lw raddr hi", ra_hist[3], 32'h104);
        run_req(1'b0, 3'b001, 32'h103, 32'h0);
        check("mis lh data", r_data, 32'h00004488);
        run_req(1'b0, 3'b001, 32'h101, 32'h0);
        check("mis lh single latency", 32'(lat), 32'd3);
        check("mis lh single data", r_data, 32'hFFFF99AA);
        run_req(1'b1, 3'b010, 32'h101, 32'hDEADBEEF);
        check("mis sw writes", 32'(nwr), 32'd4);
        check("mis sw latency", 32'(lat), 32'd5);
        check("mis sw addr0", wr_addr[0], 32'h101);
        check("mis sw addr3", wr_addr[3], 32'h104);
        check("mis sw data3", wr_data[3], 32'h000000DE);
        run_req(1'b0, 3'b010, 32'h100, 32'h0);
        check("lw 100 after mis sw", r_data, 32'hADBEEFBB);
        run_req(1'b0, 3'b010, 32'h104, 32'h0);
        check("lw 104 after mis sw", r_data, 32'h112233DE);
        run_req(1'b1, 3'b001, 32'hFFFFFFFF, 32'h00005A6B);
        check("wrap sh addr0", wr_addr[0], 32'hFFFFFFFF);
        check("wrap sh addr1", wr_addr[1], 32'h00000000);
`else
        run_req(1'b0, 3'b010, 32'h102, 32'h0);
        check("mis lw latency", 32'(lat), 32'd1);
        check("mis lw error", 32'(r_err), 32'd1);
        check("mis lw data", r_data, 32'h0);
        check("mis lw raddr", ra_hist[1], 32'h0);
        run_req(1'b1, 3'b010, 32'h101, 32'hDEADBEEF);
        check("mis sw error", 32'(r_err), 32'd1);
        check("mis sw writes", 32'(nwr), 32'd0);
`endif

        // Reset during WAIT of an aligned load
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort raddr in wait", mem_read_address, 32'h100);
        check("abort ready in wait", 32'(req_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("abort raddr", mem_read_address, 32'h0);
        check("abort funct3", 32'(mem_funct3), 32'd2);
        check("abort ready", 32'(req_ready), 32'd1);
        check("abort rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("abort rsp_valid held", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post reset ready", 32'(req_ready), 32'd1);
        check("post reset rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("post reset no rsp", 32'(rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
